// File: rtl/timer_ctrl_if.sv
// Button pulses and live counter digits in; BCD preset, load strobe, count mode and alarm out.
interface timer_ctrl_if;
    logic       btn_set;
    logic       btn_inc;
    logic       btn_start;
    logic [3:0] cnt_min1;
    logic [3:0] cnt_min0;
    logic [3:0] cnt_sec1;
    logic [3:0] cnt_sec0;
    logic [3:0] in_min1;
    logic [3:0] in_min0;
    logic [3:0] in_sec1;
    logic [3:0] in_sec0;
    logic       switch;
    logic [1:0] alu;
    logic       alarm;
    logic [2:0] state_o;

    modport master (
        output btn_set, btn_inc, btn_start,
        output cnt_min1, cnt_min0, cnt_sec1, cnt_sec0,
        input  in_min1, in_min0, in_sec1, in_sec0,
        input  switch, alu, alarm, state_o
    );

    modport slave (
        input  btn_set, btn_inc, btn_start,
        input  cnt_min1, cnt_min0, cnt_sec1, cnt_sec0,
        output in_min1, in_min0, in_sec1, in_sec0,
        output switch, alu, alarm, state_o
    );
endinterface

// File: rtl/timer_ctrl.sv
// Timer control FSM: button pulses -> BCD preset, load strobe, count mode, alarm; one-edge latency,
// alu reacts combinationally to the counters reaching 00:00; no backpressure, every pulse acts or is dropped.
module timer_ctrl #(
    parameter int ALARM_TICKS  = 10,
    parameter int MAX_MIN_TENS = 5
) (
    input  logic         clk_out,
    input  logic         rst,
    timer_ctrl_if.slave  bus
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SET_MIN = 3'd1;
    localparam logic [2:0] ST_SET_SEC = 3'd2;
    localparam logic [2:0] ST_RUN     = 3'd3;
    localparam logic [2:0] ST_PAUSE   = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    localparam logic [3:0] MIN_TENS_MAX = 4'(MAX_MIN_TENS);
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [7:0] ALARM_LAST   = 8'(ALARM_TICKS - 1);

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [3:0] r_min1;
    logic [3:0] r_min0;
    logic [3:0] r_sec1;
    logic [3:0] r_sec0;
    logic [3:0] w_min1_nxt;
    logic [3:0] w_min0_nxt;
    logic [3:0] w_sec1_nxt;
    logic [3:0] w_sec0_nxt;
    logic [7:0] r_alarm_cnt;
    logic [7:0] w_alarm_cnt_nxt;
    logic       r_alarm;

    logic       w_zero_det;
    logic       w_set;
    logic       w_start;
    logic       w_inc;
    logic       w_any_btn;

    assign w_zero_det = (bus.cnt_min1 == 4'd0) && (bus.cnt_min0 == 4'd0) &&
                        (bus.cnt_sec1 == 4'd0) && (bus.cnt_sec0 == 4'd0);

    // Coincident pulses: set beats start beats inc; losers are simply dropped.
    assign w_set     = bus.btn_set;
    assign w_start   = bus.btn_start & ~bus.btn_set;
    assign w_inc     = bus.btn_inc & ~bus.btn_set & ~bus.btn_start;
    assign w_any_btn = bus.btn_set | bus.btn_start | bus.btn_inc;

    always_comb begin
        w_state_nxt     = r_state;
        w_min1_nxt      = r_min1;
        w_min0_nxt      = r_min0;
        w_sec1_nxt      = r_sec1;
        w_sec0_nxt      = r_sec0;
        w_alarm_cnt_nxt = 8'd0;

        case (r_state)
            ST_IDLE: begin
                if (w_set) begin
                    w_state_nxt = ST_SET_MIN;
                end else if (w_start && !w_zero_det) begin
                    w_state_nxt = ST_RUN;
                end
            end

            ST_SET_MIN: begin
                if (w_set) begin
                    w_state_nxt = ST_SET_SEC;
                end else if (w_inc) begin
                    // Upset (non-BCD) digits are scrubbed to 0 instead of incremented.
                    if (r_min1 > 4'd9 || r_min0 > 4'd9) begin
                        if (r_min1 > 4'd9) w_min1_nxt = 4'd0;
                        if (r_min0 > 4'd9) w_min0_nxt = 4'd0;
                    end else if (r_min0 == 4'd9) begin
                        w_min0_nxt = 4'd0;
                        w_min1_nxt = (r_min1 >= MIN_TENS_MAX) ? 4'd0 : r_min1 + 4'd1;
                    end else begin
                        w_min0_nxt = r_min0 + 4'd1;
                    end
                end
            end

            ST_SET_SEC: begin
                if (w_set) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_inc) begin
                    if (r_sec1 > 4'd9 || r_sec0 > 4'd9) begin
                        if (r_sec1 > 4'd9) w_sec1_nxt = 4'd0;
                        if (r_sec0 > 4'd9) w_sec0_nxt = 4'd0;
                    end else if (r_sec0 == 4'd9) begin
                        w_sec0_nxt = 4'd0;
                        w_sec1_nxt = (r_sec1 >= SEC_TENS_MAX) ? 4'd0 : r_sec1 + 4'd1;
                    end else begin
                        w_sec0_nxt = r_sec0 + 4'd1;
                    end
                end
            end

            ST_RUN: begin
                // Reaching zero wins over a pause request so the alarm is never lost.
                if (w_zero_det) begin
                    w_state_nxt = ST_DONE;
                end else if (w_start) begin
                    w_state_nxt = ST_PAUSE;
                end
            end

            ST_PAUSE: begin
                if (w_set) begin
                    w_state_nxt = ST_SET_MIN;
                end else if (w_start && !w_zero_det) begin
                    w_state_nxt = ST_RUN;
                end
            end

            ST_DONE: begin
                if (w_any_btn || r_alarm_cnt == ALARM_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_alarm_cnt_nxt = r_alarm_cnt + 8'd1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_min1      <= 4'd0;
            r_min0      <= 4'd0;
            r_sec1      <= 4'd0;
            r_sec0      <= 4'd0;
            r_alarm_cnt <= 8'd0;
            r_alarm     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_min1      <= w_min1_nxt;
            r_min0      <= w_min0_nxt;
            r_sec1      <= w_sec1_nxt;
            r_sec0      <= w_sec0_nxt;
            r_alarm_cnt <= w_alarm_cnt_nxt;
            r_alarm     <= (w_state_nxt == ST_DONE);
        end
    end

    assign bus.in_min1 = r_min1;
    assign bus.in_min0 = r_min0;
    assign bus.in_sec1 = r_sec1;
    assign bus.in_sec0 = r_sec0;
    assign bus.switch  = (r_state == ST_SET_MIN) || (r_state == ST_SET_SEC);
    // Combinational so counting stops in the very cycle the digits hit 00:00.
    assign bus.alu     = (r_state == ST_RUN && !w_zero_det) ? 2'b01 : 2'b00;
    assign bus.alarm   = r_alarm;
    assign bus.state_o = r_state;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: stimulus queues time-tagged expectations, a monitor compares them when due.
module tb_timer_ctrl;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SET_MIN = 3'd1;
    localparam logic [2:0] SET_SEC = 3'd2;
    localparam logic [2:0] RUN     = 3'd3;
    localparam logic [2:0] PAUSE   = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    typedef struct {
        string       nm;
        longint      t;
        logic [2:0]  st;
        logic [15:0] pre;
        logic        sw;
        logic [1:0]  alu;
        logic        al;
    } exp_t;

    logic clk;
    logic rst;
    exp_t q[$];
    int   total;
    int   bad;

    timer_ctrl_if tif();

    timer_ctrl #(.ALARM_TICKS(10), .MAX_MIN_TENS(5)) dut (
        .clk_out (clk),
        .rst     (rst),
        .bus     (tif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input string nm, input int dt, input logic [2:0] st,
                            input logic [15:0] pre, input logic sw, input logic [1:0] alu,
                            input logic al);
        exp_t e;
        e.nm  = nm;
        e.t   = longint'($time) + longint'(dt);
        e.st  = st;
        e.pre = pre;
        e.sw  = sw;
        e.alu = alu;
        e.al  = al;
        q.push_back(e);
    endtask

    // Expectation sampled just after the coming rising edge.
    task automatic chk(input string nm, input logic [2:0] st, input logic [15:0] pre,
                       input logic sw, input logic [1:0] alu, input logic al);
        push_exp(nm, 6, st, pre, sw, alu, al);
    endtask

    // Expectation sampled before the coming rising edge.
    task automatic now(input string nm, input logic [2:0] st, input logic [15:0] pre,
                       input logic sw, input logic [1:0] alu, input logic al);
        push_exp(nm, 1, st, pre, sw, alu, al);
    endtask

    task automatic cyc(input logic s, input logic i, input logic st);
        @(negedge clk);
        tif.btn_set   = s;
        tif.btn_inc   = i;
        tif.btn_start = st;
    endtask

    task automatic set_cnt(input logic [15:0] v);
        tif.cnt_min1 = v[15:12];
        tif.cnt_min0 = v[11:8];
        tif.cnt_sec1 = v[7:4];
        tif.cnt_sec0 = v[3:0];
    endtask

    // Monitor: compares every expectation whose sample time has arrived.
    initial begin
        int          k;
        logic [15:0] a_pre;
        forever begin
            #1;
            k = 0;
            while (k < q.size()) begin
                if (q[k].t <= longint'($time)) begin
                    a_pre = {tif.in_min1, tif.in_min0, tif.in_sec1, tif.in_sec0};
                    total++;
                    if (tif.state_o !== q[k].st || a_pre !== q[k].pre || tif.switch !== q[k].sw ||
                        tif.alu !== q[k].alu || tif.alarm !== q[k].al) begin
                        bad++;
                        $display("FAIL %s: got st=%0d pre=%h sw=%b alu=%b al=%b want st=%0d pre=%h sw=%b alu=%b al=%b",
                                 q[k].nm, tif.state_o, a_pre, tif.switch, tif.alu, tif.alarm,
                                 q[k].st, q[k].pre, q[k].sw, q[k].alu, q[k].al);
                    end
                    q.delete(k);
                end else begin
                    k++;
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        tif.btn_set   = 1'b0;
        tif.btn_inc   = 1'b0;
        tif.btn_start = 1'b0;
        set_cnt(16'h0000);

        @(negedge clk);
        now("reset_init", IDLE, 16'h0000, 1'b0, 2'b00, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Minute wrap from 00, then build 01:30 and run it.
        cyc(1, 0, 0); chk("enter_set_min", SET_MIN, 16'h0000, 1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 60; i++) begin
            cyc(0, 1, 0);
            if (i == 58) chk("min_59", SET_MIN, 16'h5900, 1'b1, 2'b00, 1'b0);
            if (i == 59) chk("min_wrap_00", SET_MIN, 16'h0000, 1'b1, 2'b00, 1'b0);
        end
        cyc(0, 1, 0); chk("min_01", SET_MIN, 16'h0100, 1'b1, 2'b00, 1'b0);
        cyc(1, 0, 0); chk("enter_set_sec_a", SET_SEC, 16'h0100, 1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 30; i++) begin
            cyc(0, 1, 0);
            if (i == 29) chk("sec_30", SET_SEC, 16'h0130, 1'b1, 2'b00, 1'b0);
        end
        cyc(1, 0, 0); chk("idle_0130", IDLE, 16'h0130, 1'b0, 2'b00, 1'b0);
        cyc(0, 0, 1); set_cnt(16'h0130);
        chk("run_0130", RUN, 16'h0130, 1'b0, 2'b01, 1'b0);
        @(negedge clk);
        tif.btn_start = 1'b0;
        rst = 1'b1;
        now("reset_in_run", IDLE, 16'h0000, 1'b0, 2'b00, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        set_cnt(16'h0000);

        // set, inc x3, set, inc x62, set -> 03:02.
        cyc(1, 0, 0); chk("set_min_b", SET_MIN, 16'h0000, 1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0);
            if (i == 2) chk("min_03", SET_MIN, 16'h0300, 1'b1, 2'b00, 1'b0);
        end
        cyc(1, 0, 0); chk("set_sec_b", SET_SEC, 16'h0300, 1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 62; i++) begin
            cyc(0, 1, 0);
            if (i == 58) chk("sec_59", SET_SEC, 16'h0359, 1'b1, 2'b00, 1'b0);
            if (i == 59) chk("sec_wrap_00", SET_SEC, 16'h0300, 1'b1, 2'b00, 1'b0);
            if (i == 61) chk("sec_02", SET_SEC, 16'h0302, 1'b1, 2'b00, 1'b0);
        end
        cyc(1, 0, 0); chk("idle_0302", IDLE, 16'h0302, 1'b0, 2'b00, 1'b0);

        // Pause / resume, then edit from PAUSE keeping the preset.
        cyc(0, 0, 1); set_cnt(16'h0302);
        chk("run_a", RUN, 16'h0302, 1'b0, 2'b01, 1'b0);
        cyc(0, 0, 1); chk("pause_a", PAUSE, 16'h0302, 1'b0, 2'b00, 1'b0);
        cyc(0, 0, 1); chk("resume", RUN, 16'h0302, 1'b0, 2'b01, 1'b0);
        cyc(0, 0, 1); chk("pause_b", PAUSE, 16'h0302, 1'b0, 2'b00, 1'b0);
        cyc(1, 0, 0); chk("pause_to_set", SET_MIN, 16'h0302, 1'b1, 2'b00, 1'b0);
        cyc(1, 0, 0); chk("set_sec_c", SET_SEC, 16'h0302, 1'b1, 2'b00, 1'b0);
        cyc(1, 0, 0); chk("idle_c", IDLE, 16'h0302, 1'b0, 2'b00, 1'b0);

        // Start refused with counters at 00:00.
        cyc(0, 0, 1); set_cnt(16'h0000);
        chk("start_at_zero", IDLE, 16'h0302, 1'b0, 2'b00, 1'b0);

        // set+start together -> SET_MIN only; set+inc together -> inc dropped.
        cyc(1, 0, 1); chk("set_beats_start", SET_MIN, 16'h0302, 1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 57; i++) begin
            cyc(0, 1, 0);
            if (i == 55) chk("min_59_b", SET_MIN, 16'h5902, 1'b1, 2'b00, 1'b0);
            if (i == 56) chk("min_00_b", SET_MIN, 16'h0002, 1'b1, 2'b00, 1'b0);
        end
        cyc(1, 1, 0); chk("set_beats_inc", SET_SEC, 16'h0002, 1'b1, 2'b00, 1'b0);
        cyc(1, 0, 0); chk("idle_0002", IDLE, 16'h0002, 1'b0, 2'b00, 1'b0);

        // Count down to zero: alu drops same cycle, alarm for 10 cycles.
        cyc(0, 0, 1); set_cnt(16'h0002);
        chk("run_0002", RUN, 16'h0002, 1'b0, 2'b01, 1'b0);
        cyc(0, 0, 0); set_cnt(16'h0001);
        chk("run_0001", RUN, 16'h0002, 1'b0, 2'b01, 1'b0);
        cyc(0, 0, 0); set_cnt(16'h0000);
        now("alu_zero_comb", RUN, 16'h0002, 1'b0, 2'b00, 1'b0);
        chk("done_entry", DONE, 16'h0002, 1'b0, 2'b00, 1'b1);
        for (int i = 0; i < 9; i++) begin
            cyc(0, 0, 0);
            chk($sformatf("alarm_%0d", i + 2), DONE, 16'h0002, 1'b0, 2'b00, 1'b1);
        end
        cyc(0, 0, 0); chk("alarm_expired", IDLE, 16'h0002, 1'b0, 2'b00, 1'b0);

        // A button pulse ends DONE early.
        cyc(0, 0, 1); set_cnt(16'h0002);
        chk("run_d", RUN, 16'h0002, 1'b0, 2'b01, 1'b0);
        cyc(0, 0, 0); set_cnt(16'h0000);
        chk("done_d", DONE, 16'h0002, 1'b0, 2'b00, 1'b1);
        cyc(0, 0, 1); chk("done_abort", IDLE, 16'h0002, 1'b0, 2'b00, 1'b0);
        cyc(0, 0, 0);

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
